// File: rtl/scs8hd_bist_pkg.sv
// rtl/scs8hd_bist_pkg.sv - shared state enum, vector count and golden function for the nor4b BIST
package scs8hd_bist_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } bist_state_e;

  localparam int NVEC  = 16;
  localparam int VEC_W = 4;
  localparam int ERR_W = 5;

  // Vector order is {A,B,C,DN}; Y is high only when A=B=C=0 and DN=1.
  function automatic logic nor4b_expected(input logic [VEC_W-1:0] vec);
    return ~vec[3] & ~vec[2] & ~vec[1] & vec[0];
  endfunction

endpackage

// File: rtl/scs8hd_nor4b_model.sv
// rtl/scs8hd_nor4b_model.sv - combinational golden model of the nor4b gate
module scs8hd_nor4b_model
  import scs8hd_bist_pkg::*;
(
  input  logic [VEC_W-1:0] i_vec,
  output logic             o_y
);

  assign o_y = nor4b_expected(i_vec);

endmodule

// File: rtl/scs8hd_nor4b_bist.sv
// rtl/scs8hd_nor4b_bist.sv - exhaustive 16-vector BIST sequencer for a nor4b standard cell
module scs8hd_nor4b_bist
  import scs8hd_bist_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 2
) (
`ifdef SC_USE_PG_PIN
  input  logic             vpwr,
  input  logic             vgnd,
  input  logic             vpb,
  input  logic             vnb,
`endif
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             start,
  input  logic             abort,
  input  logic             dut_y,
  output logic             tst_a,
  output logic             tst_b,
  output logic             tst_c,
  output logic             tst_dn,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic             first_fail_vld,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam logic [3:0]       SETTLE_LAST = (SETTLE_CYC == 0) ? 4'd0 : 4'(SETTLE_CYC - 1);
  localparam logic [VEC_W-1:0] VEC_LAST    = VEC_W'(NVEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX     = ERR_W'(NVEC);

  bist_state_e      r_state, w_state_nxt;
  logic [VEC_W-1:0] r_vec, w_vec_nxt;
  logic [3:0]       r_settle, w_settle_nxt;
  logic [VEC_W-1:0] r_stim, w_stim_nxt;
  logic [ERR_W-1:0] r_err_cnt;
  logic             r_ff_vld;
  logic [VEC_W-1:0] r_ff_vec;
  logic             w_exp_y;
  logic             w_clear;
  logic             w_mismatch;

  scs8hd_nor4b_model u_model (
    .i_vec (r_stim),
    .o_y   (w_exp_y)
  );

  always_comb begin
    w_state_nxt  = r_state;
    w_vec_nxt    = r_vec;
    w_settle_nxt = r_settle;
    w_clear      = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_state_nxt = ST_APPLY;
            w_vec_nxt   = '0;
            w_clear     = 1'b1;
          end
        end
        ST_APPLY: begin
          w_settle_nxt = '0;
          w_state_nxt  = (SETTLE_CYC == 0) ? ST_SAMPLE : ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_settle == SETTLE_LAST) w_state_nxt = ST_SAMPLE;
          else                         w_settle_nxt = r_settle + 4'd1;
        end
        ST_SAMPLE: begin
          if (r_vec == VEC_LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_vec_nxt   = r_vec + 4'd1;
            w_state_nxt = ST_APPLY;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Stimulus is registered from the next state so it is already valid in the APPLY cycle.
  always_comb begin
    w_stim_nxt = '0;
    if (w_state_nxt == ST_APPLY || w_state_nxt == ST_SETTLE || w_state_nxt == ST_SAMPLE)
      w_stim_nxt = w_vec_nxt;
  end

  assign w_mismatch = !abort && (r_state == ST_SAMPLE) && (dut_y != w_exp_y);

  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_state   <= ST_IDLE;
      r_vec     <= '0;
      r_settle  <= '0;
      r_stim    <= '0;
      r_err_cnt <= '0;
      r_ff_vld  <= 1'b0;
      r_ff_vec  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_vec    <= w_vec_nxt;
      r_settle <= w_settle_nxt;
      r_stim   <= w_stim_nxt;
      if (w_clear) begin
        r_err_cnt <= '0;
        r_ff_vld  <= 1'b0;
        r_ff_vec  <= '0;
      end else if (w_mismatch) begin
        if (r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + 5'd1;
        if (!r_ff_vld) begin
          r_ff_vld <= 1'b1;
          r_ff_vec <= r_vec;
        end
      end
    end
  end

  assign {tst_a, tst_b, tst_c, tst_dn} = r_stim;
  assign busy           = (r_state == ST_APPLY) || (r_state == ST_SETTLE) || (r_state == ST_SAMPLE);
  assign done           = (r_state == ST_DONE);
  assign pass           = done && (r_err_cnt == '0);
  assign err_cnt        = r_err_cnt;
  assign first_fail_vld = r_ff_vld;
  assign first_fail_vec = r_ff_vec;

endmodule

// File: doc/scs8hd_nor4b_bist.md
SCS8HD_NOR4B_BIST -- requirements
Module: scs8hd_nor4b_bist

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 2, meaning the wait cycles between applying a vector and sampling the gate output (legal 0..15).
REQ-002 SHALL have port CLK, input, 1 bit: single clock, all state updates on its rising edge.
REQ-003 SHALL have port RESETB, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port start, input, 1 bit: request a full 16-vector test.
REQ-005 SHALL have port abort, input, 1 bit: synchronous cancel of a running test.
REQ-006 SHALL have port dut_y, input, 1 bit: output Y of the nor4b gate under test.
REQ-007 SHALL have ports tst_a, tst_b, tst_c, tst_dn, output, 1 bit each: registered stimulus to gate inputs A, B, C, DN.
REQ-008 SHALL have port busy, output, 1 bit: high while a test runs.
REQ-009 SHALL have port done, output, 1 bit: high while results are held.
REQ-010 SHALL have port pass, output, 1 bit: meaningful only while done=1; high when err_cnt==0.
REQ-011 SHALL have port err_cnt, output, 5 bits: count of mismatching vectors (0..16).
REQ-012 SHALL have ports first_fail_vld (1 bit) and first_fail_vec (4 bits), outputs: first failing vector {A,B,C,DN}, valid flag.
REQ-013 SHALL add inputs vpwr, vgnd, vpb, vnb only when SC_USE_PG_PIN is defined.

Function
REQ-014 SHALL implement FSM states IDLE, APPLY, SETTLE, SAMPLE, DONE.
REQ-015 SHALL, in IDLE or DONE with start=1, clear err_cnt, first_fail_vld, first_fail_vec and the vector counter to 0, and go to APPLY.
REQ-016 SHALL ignore start in APPLY, SETTLE and SAMPLE.
REQ-017 SHALL drive {tst_a,tst_b,tst_c,tst_dn} = vector counter[3:0] from the APPLY cycle through the SAMPLE cycle.
REQ-018 SHALL stay 1 cycle in APPLY, then SETTLE_CYC cycles in SETTLE, skipping SETTLE when SETTLE_CYC=0, then 1 cycle in SAMPLE.
REQ-019 SHALL give each vector 2+SETTLE_CYC cycles, so a full test lasts 16*(2+SETTLE_CYC) cycles: 64 at the default.
REQ-020 SHALL, in SAMPLE, compare dut_y with expected = ~A & ~B & ~C & DN, so only vector 4'b0001 expects 1.
REQ-021 SHALL, on a mismatch, increment err_cnt, and if first_fail_vld=0, capture the vector and set first_fail_vld.
REQ-022 SHALL, after SAMPLE, go to DONE if the vector counter is 15, otherwise increment the counter and return to APPLY.
REQ-023 SHALL, in DONE, hold done=1, pass=(err_cnt==0), and err_cnt and first-fail outputs stable until start, abort or reset.
REQ-024 SHALL, on abort=1 in any state, go to IDLE next cycle: busy=0, done=0, stimulus 4'b0000, err_cnt held.
REQ-025 SHALL give abort priority over start when both are asserted in the same cycle.
REQ-026 SHALL keep busy=1 exactly in APPLY, SETTLE and SAMPLE.
REQ-027 SHALL hold err_cnt at 16 without wrapping.

Reset
REQ-028 SHALL, while RESETB=0, asynchronously force state IDLE and set all outputs and counters to 0 (stimulus 4'b0000, pass=0).
REQ-029 SHALL, when RESETB asserts mid-test, discard partial results; the next start begins from vector 0.
REQ-030 SHALL wait until the first rising CLK edge after RESETB rises before acting on start.

Structure
REQ-031 SHALL take the state enum, NVEC=16 and the expected-value function from shared package scs8hd_bist_pkg.
REQ-032 SHALL instantiate one sub-module, scs8hd_nor4b_model: a combinational golden model mapping {A,B,C,DN} to expected Y.
REQ-033 SHALL hold the settle counter, vector counter and FSM in the top module.

Verification
REQ-034 SHALL cover an ideal gate model, SETTLE_CYC=2, start pulse -> done after 64 cycles, pass=1, err_cnt=0, first_fail_vld=0.
REQ-035 SHALL cover dut_y stuck at 0 -> err_cnt=1, first_fail_vec=4'b0001, pass=0.
REQ-036 SHALL cover dut_y stuck at 1 -> err_cnt=15, first_fail_vec=4'b0000.
REQ-037 SHALL cover abort at cycle 20 of a test -> IDLE next cycle, busy=0, stimulus 0; a new start then completes in 64 cycles with pass=1.
REQ-038 SHALL cover RESETB low for 3 cycles mid-SETTLE -> all outputs 0 immediately, without waiting for a clock edge.
REQ-039 SHALL cover SETTLE_CYC=0 -> done after 32 cycles; start during busy has no effect, and start in DONE reruns with cleared results.
